// File: rtl/sdram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter_if
// Brief    : Requester-side and controller-side bus of the SDRAM port arbiter.
//            The slave modport is the arbiter's view. The master modport is the
//            surrounding system: the requesters and the SDRAM controller.
// Revision : 1.0 - initial release
// ============================================================================
interface sdram_port_arbiter_if #(
    parameter int NUM_PORTS = 3
);
    // Requester side
    logic [NUM_PORTS-1:0]    req_valid;
    logic [NUM_PORTS-1:0]    req_we;
    logic [24*NUM_PORTS-1:0] req_addr;
    logic [16*NUM_PORTS-1:0] req_wdata;
    logic [NUM_PORTS-1:0]    req_ready;
    logic [NUM_PORTS-1:0]    rsp_valid;
    logic                    rsp_err;
    logic [15:0]             rsp_rdata;

    // Controller side
    logic [23:0]             mem_addr;
    logic                    mem_wr_req;
    logic                    mem_rd_req;
    logic [15:0]             mem_wr_data;
    logic [15:0]             mem_rd_data;
    logic                    mem_rd_ready;
    logic                    mem_wr_done;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        input  mem_rd_data, mem_rd_ready, mem_wr_done,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output mem_addr, mem_wr_req, mem_rd_req, mem_wr_data
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        output mem_rd_data, mem_rd_ready, mem_wr_done,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  mem_addr, mem_wr_req, mem_rd_req, mem_wr_data
    );
endinterface
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter
// Brief    : Round-robin sharing of a single-access SDRAM controller among
//            NUM_PORTS requesters. One transaction is outstanding at a time.
//            Controller requests are held until completion, and a watchdog
//            aborts transactions that never complete.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter #(
    parameter int NUM_PORTS      = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic              clk_100MHz,
    input  wire logic              rst,
    sdram_port_arbiter_if.slave    bus
);

    localparam int                 c_IDX_W   = $clog2(NUM_PORTS);
    localparam int                 c_WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_IDX_W:0]   c_NUM_EXT = (c_IDX_W+1)'(NUM_PORTS);
    localparam logic [c_WD_W-1:0]  c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t                 state_q,       state_d;
    logic [c_IDX_W-1:0]     last_grant_q,  last_grant_d;
    logic [c_IDX_W-1:0]     owner_q,       owner_d;
    logic                   we_q,          we_d;
    logic [c_WD_W-1:0]      wdog_q,        wdog_d;
    logic [NUM_PORTS-1:0]   req_ready_q,   req_ready_d;
    logic [NUM_PORTS-1:0]   rsp_valid_q,   rsp_valid_d;
    logic                   rsp_err_q,     rsp_err_d;
    logic [15:0]            rsp_rdata_q,   rsp_rdata_d;
    logic [23:0]            mem_addr_q,    mem_addr_d;
    logic                   mem_wr_req_q,  mem_wr_req_d;
    logic                   mem_rd_req_q,  mem_rd_req_d;
    logic [15:0]            mem_wr_data_q, mem_wr_data_d;

    logic                   w_grant_found;
    logic [c_IDX_W-1:0]     w_grant_idx;
    logic [c_IDX_W:0]       w_cand;
    logic                   w_sel_we;
    logic [23:0]            w_sel_addr;
    logic [15:0]            w_sel_wdata;
    logic                   w_done;

    // Round-robin search: first requesting port above last_grant, wrapping.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_cand        = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            w_cand = {1'b0, last_grant_q} + (c_IDX_W+1)'(i);
            if (w_cand >= c_NUM_EXT) begin
                w_cand = w_cand - c_NUM_EXT;
            end
            if (!w_grant_found && bus.req_valid[w_cand[c_IDX_W-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand[c_IDX_W-1:0];
            end
        end
    end

    // Select the winning port's direction, address and write data.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_grant_idx == c_IDX_W'(p)) begin
                w_sel_we    = bus.req_we[p];
                w_sel_addr  = bus.req_addr[p*24 +: 24];
                w_sel_wdata = bus.req_wdata[p*16 +: 16];
            end
        end
    end

    // A completion counts only when it matches the direction that was issued.
    assign w_done = we_q ? bus.mem_wr_done : bus.mem_rd_ready;

    // Next-state and output logic. Pulses default to low and the datapath holds.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        we_d          = we_q;
        wdog_d        = wdog_q;
        req_ready_d   = '0;
        rsp_valid_d   = '0;
        rsp_err_d     = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_req_d  = mem_wr_req_q;
        mem_rd_req_d  = mem_rd_req_q;
        mem_wr_data_d = mem_wr_data_q;

        case (state_q)
            ST_ARB: begin
                if (w_grant_found) begin
                    req_ready_d[w_grant_idx] = 1'b1;
                    owner_d       = w_grant_idx;
                    last_grant_d  = w_grant_idx;
                    we_d          = w_sel_we;
                    mem_addr_d    = w_sel_addr;
                    mem_wr_data_d = w_sel_wdata;
                    mem_wr_req_d  = w_sel_we;
                    mem_rd_req_d  = !w_sel_we;
                    wdog_d        = '0;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Completion takes priority over a simultaneous timeout.
                if (w_done) begin
                    mem_wr_req_d         = 1'b0;
                    mem_rd_req_d         = 1'b0;
                    rsp_valid_d[owner_q] = 1'b1;
                    if (!we_q) begin
                        rsp_rdata_d = bus.mem_rd_data;
                    end
                    state_d = ST_GAP;
                end else if (wdog_q == c_WD_LAST) begin
                    mem_wr_req_d         = 1'b0;
                    mem_rd_req_d         = 1'b0;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_err_d            = 1'b1;
                    state_d              = ST_GAP;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_GAP: begin
                // The controller must see both requests low before the next ACTIVE.
                state_d = ST_ARB;
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // State and output registers. Reset drops requests and suppresses any response.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_q       <= ST_ARB;
            last_grant_q  <= c_IDX_W'(NUM_PORTS - 1);
            owner_q       <= '0;
            we_q          <= 1'b0;
            wdog_q        <= '0;
            req_ready_q   <= '0;
            rsp_valid_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= '0;
            mem_addr_q    <= '0;
            mem_wr_req_q  <= 1'b0;
            mem_rd_req_q  <= 1'b0;
            mem_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            we_q          <= we_d;
            wdog_q        <= wdog_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_rdata_q   <= rsp_rdata_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_req_q  <= mem_wr_req_d;
            mem_rd_req_q  <= mem_rd_req_d;
            mem_wr_data_q <= mem_wr_data_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wr_req  = mem_wr_req_q;
    assign bus.mem_rd_req  = mem_rd_req_q;
    assign bus.mem_wr_data = mem_wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_port_arbiter
// Brief    : Directed self-checking bench for sdram_port_arbiter (3 ports,
//            64-cycle timeout). The bench plays both the requesters and the
//            SDRAM controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter_if #(.NUM_PORTS(3)) bus ();

    sdram_port_arbiter #(
        .NUM_PORTS      (3),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk_100MHz (clk),
        .rst        (rst),
        .bus        (bus.slave)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(output logic [2:0] g);
        int n;
        n = 0;
        while (bus.req_ready == 3'b000 && n < 20) begin
            tick();
            n++;
        end
        check_val("grant_wait", (n < 20) ? 32'd1 : 32'd0, 32'd1);
        g = bus.req_ready;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [2:0] g;
        logic [2:0] exp_g;
        bit         ok;

        rst              = 1'b1;
        bus.req_valid    = '0;
        bus.req_we       = '0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.mem_rd_data  = '0;
        bus.mem_rd_ready = 1'b0;
        bus.mem_wr_done  = 1'b0;
        repeat (3) tick();

        // Reset values
        check_val("rst_req_ready",   bus.req_ready,   0);
        check_val("rst_rsp_valid",   bus.rsp_valid,   0);
        check_val("rst_rsp_err",     bus.rsp_err,     0);
        check_val("rst_rsp_rdata",   bus.rsp_rdata,   0);
        check_val("rst_mem_addr",    bus.mem_addr,    0);
        check_val("rst_mem_reqs",    {bus.mem_wr_req, bus.mem_rd_req}, 0);
        check_val("rst_mem_wr_data", bus.mem_wr_data, 0);
        rst = 1'b0;

        // Single read: port 1 reads 0x123456, controller answers 0xBEEF after 6 cycles
        bus.req_we             = 3'b000;
        bus.req_addr[24 +: 24] = 24'h123456;
        bus.req_valid          = 3'b010;
        wait_grant(g);
        check_val("t1_grant",    g, 3'b010);
        check_val("t1_rd_req",   {bus.mem_wr_req, bus.mem_rd_req}, 2'b01);
        check_val("t1_addr",     bus.mem_addr, 24'h123456);
        bus.req_valid = 3'b000;
        ok = 1'b1;
        repeat (5) begin
            tick();
            if (!(bus.mem_rd_req == 1'b1 && bus.req_ready == 3'b000 && bus.rsp_valid == 3'b000)) ok = 1'b0;
        end
        check_val("t1_hold", ok, 1);
        bus.mem_rd_data  = 16'hBEEF;
        bus.mem_rd_ready = 1'b1;
        tick();
        bus.mem_rd_ready = 1'b0;
        bus.mem_rd_data  = 16'h0000;
        check_val("t1_rsp_valid", bus.rsp_valid, 3'b010);
        check_val("t1_rsp_rdata", bus.rsp_rdata, 16'hBEEF);
        check_val("t1_rsp_err",   bus.rsp_err,   0);
        check_val("t1_rd_drop",   bus.mem_rd_req, 0);

        // Write hold: port 0 writes 0xA5A5 to 0x000010, done 4 cycles later
        bus.req_we[0]         = 1'b1;
        bus.req_addr[0 +: 24] = 24'h000010;
        bus.req_wdata[0 +: 16] = 16'hA5A5;
        bus.req_valid         = 3'b001;
        wait_grant(g);
        check_val("t2_grant",   g, 3'b001);
        check_val("t2_wr_req",  {bus.mem_wr_req, bus.mem_rd_req}, 2'b10);
        check_val("t2_addr",    bus.mem_addr, 24'h000010);
        check_val("t2_wdata",   bus.mem_wr_data, 16'hA5A5);
        bus.req_valid = 3'b000;
        ok = 1'b1;
        repeat (3) begin
            tick();
            if (!(bus.mem_addr == 24'h000010 && bus.mem_wr_data == 16'hA5A5 && bus.mem_wr_req == 1'b1)) ok = 1'b0;
        end
        check_val("t2_hold", ok, 1);
        bus.mem_wr_done = 1'b1;
        tick();
        bus.mem_wr_done = 1'b0;
        check_val("t2_wr_drop",   bus.mem_wr_req, 0);
        check_val("t2_rsp_valid", bus.rsp_valid, 3'b001);
        check_val("t2_rsp_err",   bus.rsp_err, 0);
        check_val("t2_rdata_keep", bus.rsp_rdata, 16'hBEEF);
        // Port 2 read becomes pending while in GAP
        bus.req_we[2]          = 1'b0;
        bus.req_addr[48 +: 24] = 24'hABCDEF;
        bus.req_valid          = 3'b100;
        tick();
        check_val("t2_gap_idle", {bus.req_ready, bus.mem_wr_req, bus.mem_rd_req}, 5'b0);
        tick();
        check_val("t2_gap_len", bus.req_ready, 3'b100);
        bus.req_valid    = 3'b000;
        bus.mem_rd_data  = 16'h5555;
        bus.mem_rd_ready = 1'b1;
        tick();
        bus.mem_rd_ready = 1'b0;
        check_val("t2_p2_rsp",   bus.rsp_valid, 3'b100);
        check_val("t2_p2_rdata", bus.rsp_rdata, 16'h5555);

        // Round-robin: all three ports request continuously
        bus.req_we    = 3'b111;
        bus.req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_g = 3'b001 << (k % 3);
            wait_grant(g);
            check_val($sformatf("rr_grant%0d", k), g, exp_g);
            if (k == 5) bus.req_valid = 3'b000;
            tick();
            bus.mem_wr_done = 1'b1;
            tick();
            bus.mem_wr_done = 1'b0;
            check_val($sformatf("rr_rsp%0d", k), bus.rsp_valid, exp_g);
        end

        // Timeout: port 1 read never completes; port 2 write is pending
        bus.req_we    = 3'b100;
        bus.req_valid = 3'b110;
        wait_grant(g);
        check_val("t4_grant", g, 3'b010);
        bus.req_valid = 3'b100;
        ok = 1'b1;
        repeat (63) begin
            tick();
            if (!(bus.mem_rd_req == 1'b1 && bus.rsp_valid == 3'b000)) ok = 1'b0;
        end
        check_val("t4_wait", ok, 1);
        tick();
        check_val("t4_rsp_valid", bus.rsp_valid, 3'b010);
        check_val("t4_rsp_err",   bus.rsp_err, 1);
        check_val("t4_rd_drop",   bus.mem_rd_req, 0);
        check_val("t4_rdata_keep", bus.rsp_rdata, 16'h5555);
        tick();
        check_val("t4_gap", bus.req_ready, 3'b000);
        tick();
        check_val("t4_next", {bus.req_ready, bus.mem_wr_req}, 4'b1001);

        // Completion in the same cycle as the timeout: completion wins
        bus.req_valid = 3'b000;
        repeat (63) tick();
        bus.mem_wr_done = 1'b1;
        tick();
        bus.mem_wr_done = 1'b0;
        check_val("t5_rsp_valid", bus.rsp_valid, 3'b100);
        check_val("t5_rsp_err",   bus.rsp_err, 0);
        check_val("t5_wr_drop",   bus.mem_wr_req, 0);

        // Spurious write-done during a read is ignored
        bus.req_we            = 3'b000;
        bus.req_addr[0 +: 24] = 24'h000777;
        bus.req_valid         = 3'b001;
        wait_grant(g);
        check_val("t6_grant", g, 3'b001);
        bus.req_valid = 3'b000;
        tick();
        bus.mem_wr_done = 1'b1;
        tick();
        bus.mem_wr_done = 1'b0;
        check_val("t6_spurious", {bus.rsp_valid, bus.mem_rd_req}, 4'b0001);
        bus.mem_rd_data  = 16'h1234;
        bus.mem_rd_ready = 1'b1;
        tick();
        bus.mem_rd_ready = 1'b0;
        check_val("t6_rsp_valid", bus.rsp_valid, 3'b001);
        check_val("t6_rsp_rdata", bus.rsp_rdata, 16'h1234);
        check_val("t6_rsp_err",   bus.rsp_err, 0);

        // Reset during ISSUE
        bus.req_we    = 3'b001;
        bus.req_valid = 3'b001;
        wait_grant(g);
        check_val("t7_grant", g, 3'b001);
        tick();
        rst           = 1'b1;
        bus.req_we    = 3'b000;
        bus.req_valid = 3'b111;
        tick();
        check_val("t7_rst_ctl", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_wr_req, bus.mem_rd_req}, 0);
        check_val("t7_rst_addr", bus.mem_addr, 0);
        check_val("t7_rst_data", {bus.rsp_rdata, bus.mem_wr_data}, 0);
        tick();
        check_val("t7_no_rsp", bus.rsp_valid, 0);
        rst = 1'b0;
        wait_grant(g);
        check_val("t7_first_grant", g, 3'b001);
        check_val("t7_rd_req", bus.mem_rd_req, 1);
        bus.req_valid = 3'b000;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
